// File: rtl/score_keep_bcd.sv
// score_keep_bcd: frame-paced BCD score keeper with coin bonus, saturation and high score
module score_keep_bcd #(
    parameter int DIGITS          = 4,
    parameter int TICKS_PER_POINT = 6,
    parameter int COIN_BONUS      = 10
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  frame_clk,
    input  logic                  playing,
    input  logic                  coin_hit,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic [4*DIGITS-1:0]   high_bcd,
    output logic [1:0]            phase,
    output logic                  new_high,
    output logic                  saturated
);
    localparam int W = 4 * DIGITS;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] OVER = 2'd2;

    // Addends carry one spare digit so COIN_BONUS+1 may reach 10^DIGITS and still flag overflow
    function automatic logic [W+3:0] to_bcd(input int v);
        int x;
        x = v;
        to_bcd = '0;
        for (int i = 0; i <= DIGITS; i++) begin
            to_bcd[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
    endfunction

    localparam logic [W+3:0] ADD_ONE    = to_bcd(1);
    localparam logic [W+3:0] ADD_BONUS  = to_bcd(COIN_BONUS);
    localparam logic [W+3:0] ADD_BONUS1 = to_bcd(COIN_BONUS + 1);
    localparam logic [W-1:0] ALL_NINES  = {DIGITS{4'h9}};

    logic           fs1, fs2, fhist, play_hist, nh;
    logic [7:0]     tick_cnt;
    logic [1:0]     state;
    logic [W-1:0]   score, high, sum, nxt;
    logic [W+3:0]   addend;
    logic           frame_tick, rise, fall, run, point_due, ovf, gt;

    assign frame_tick = fs2 & ~fhist;
    assign rise       = playing & ~play_hist;
    assign fall       = ~playing & play_hist;
    assign run        = state == RUN;
    assign point_due  = run & frame_tick & (tick_cnt == 8'(TICKS_PER_POINT - 1));
    assign addend     = coin_hit ? (point_due ? ADD_BONUS1 : ADD_BONUS) : (point_due ? ADD_ONE : '0);

    // Decimal ripple add of the addend onto the score; clamp to all nines on overflow
    always_comb begin
        logic       c;
        logic [4:0] s;
        c   = 1'b0;
        sum = '0;
        for (int i = 0; i < DIGITS; i++) begin
            s = {1'b0, score[4*i +: 4]} + {1'b0, addend[4*i +: 4]} + {4'b0, c};
            c = s > 5'd9;
            sum[4*i +: 4] = c ? 4'(s - 5'd10) : s[3:0];
        end
        ovf = c | (addend[W +: 4] != 4'h0);
        nxt = ovf ? ALL_NINES : sum;
    end

    // Digit-wise magnitude compare of score against high, most significant digit first
    always_comb begin
        logic done;
        gt   = 1'b0;
        done = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (!done && score[4*i +: 4] != high[4*i +: 4]) begin
                gt   = score[4*i +: 4] > high[4*i +: 4];
                done = 1'b1;
            end
        end
    end

    // Frame strobe synchroniser with edge history, plus raw history of playing
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fs1       <= 1'b0;
            fs2       <= 1'b0;
            fhist     <= 1'b0;
            play_hist <= 1'b0;
        end else begin
            fs1       <= frame_clk;
            fs2       <= fs1;
            fhist     <= fs2;
            play_hist <= playing;
        end
    end

    // Game FSM; a playing edge wins over any pending point or coin in the same cycle
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            score    <= '0;
            high     <= '0;
            tick_cnt <= '0;
            nh       <= 1'b0;
        end else if (!run && rise) begin
            state    <= RUN;
            score    <= '0;
            tick_cnt <= '0;
            nh       <= 1'b0;
        end else if (run && fall) begin
            state <= OVER;
            if (gt) begin
                high <= score;
                nh   <= 1'b1;
            end
        end else if (run) begin
            if (frame_tick)
                tick_cnt <= point_due ? 8'd0 : tick_cnt + 8'd1;
            score <= nxt;
        end
    end

    assign score_bcd = score;
    assign high_bcd  = high;
    assign phase     = state;
    assign new_high  = nh & (state == OVER);
    assign saturated = score == ALL_NINES;
endmodule

// File: tb/tb_score_keep_bcd.sv
// tb_score_keep_bcd: directed scoreboard bench for score_keep_bcd with default parameters
module tb_score_keep_bcd;
    logic        Clk = 1'b0;
    logic        Reset = 1'b0, frame_clk = 1'b0, playing = 1'b0, coin_hit = 1'b0;
    logic [15:0] score_bcd, high_bcd;
    logic [1:0]  phase;
    logic        new_high, saturated;

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;

    exp_t q[$];
    int   total = 0, bad = 0;
    int   sc = 0, tk = 0, hi = 0;
    bit   run_m = 0, nh_m = 0;

    score_keep_bcd dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .playing(playing), .coin_hit(coin_hit),
        .score_bcd(score_bcd), .high_bcd(high_bcd), .phase(phase), .new_high(new_high),
        .saturated(saturated)
    );

    always #5 Clk = ~Clk;

    function automatic logic [15:0] bcd(input int v);
        logic [15:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.v = v;
        q.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        total++;
        if (q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty: observed=%h expected=<entry>", obs);
        end else begin
            e = q.pop_front();
            assert (obs === e.v) else begin
                bad++;
                $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] v);
        push(tag, v);
        pop_chk(obs);
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_score"}, 32'(score_bcd), 32'(bcd(sc)));
        chk({tag, "_high"}, 32'(high_bcd), 32'(bcd(hi)));
        chk({tag, "_phase"}, 32'(phase), run_m ? 32'd1 : 32'(phase == 2'd2 ? 2 : 0));
        chk({tag, "_sat"}, 32'(saturated), 32'(sc == 9999));
    endtask

    task automatic coin(input string tag);
        if (run_m) sc = (sc + 10 > 9999) ? 9999 : sc + 10;
        push(tag, 32'(bcd(sc)));
        coin_hit = 1'b1;
        step();
        coin_hit = 1'b0;
        pop_chk(32'(score_bcd));
    endtask

    task automatic pulse(input string tag, input bit c);
        int p;
        if (run_m) begin
            tk++;
            p = (tk == 6) ? 1 : 0;
            if (p == 1) tk = 0;
            sc = sc + p + (c ? 10 : 0);
            if (sc > 9999) sc = 9999;
        end
        push(tag, 32'(bcd(sc)));
        frame_clk = 1'b1;
        step();
        step();
        coin_hit = c;
        step();
        coin_hit = 1'b0;
        frame_clk = 1'b0;
        repeat (3) step();
        pop_chk(32'(score_bcd));
    endtask

    task automatic start_run();
        playing = 1'b1;
        step();
        run_m = 1;
        sc = 0;
        tk = 0;
        nh_m = 0;
    endtask

    task automatic end_run();
        playing = 1'b0;
        step();
        run_m = 0;
        nh_m = sc > hi;
        if (nh_m) hi = sc;
    endtask

    initial begin
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check_all("reset");
        chk("reset_new_high", 32'(new_high), 32'd0);

        coin("idle_coin");
        pulse("idle_pulse", 1'b1);

        start_run();
        chk("run_phase", 32'(phase), 32'd1);
        for (int i = 0; i < 11; i++) pulse("tick_run", 1'b0);
        frame_clk = 1'b1;
        step();
        step();
        chk("latency_2edges", 32'(score_bcd), 32'h0001);
        step();
        chk("latency_3edges", 32'(score_bcd), 32'h0002);
        frame_clk = 1'b0;
        repeat (3) step();
        sc = 2;
        tk = 0;

        for (int i = 0; i < 4; i++) coin("coin_to_42");
        end_run();
        chk("end1_phase", 32'(phase), 32'd2);
        chk("end1_high", 32'(high_bcd), 32'h0042);
        chk("end1_new_high", 32'(new_high), 32'd1);

        coin("over_coin");
        pulse("over_pulse", 1'b0);
        chk("over_hold", 32'(score_bcd), 32'h0042);

        start_run();
        for (int i = 0; i < 3; i++) coin("coin_to_30");
        end_run();
        chk("end2_high", 32'(high_bcd), 32'h0042);
        chk("end2_new_high", 32'(new_high), 32'd0);
        chk("end2_phase", 32'(phase), 32'd2);

        playing = 1'b1;
        coin_hit = 1'b1;
        step();
        coin_hit = 1'b0;
        run_m = 1;
        sc = 0;
        tk = 0;
        chk("edge_wins_score", 32'(score_bcd), 32'h0000);
        chk("edge_wins_phase", 32'(phase), 32'd1);

        for (int i = 0; i < 9; i++) coin("coin_to_90");
        for (int i = 0; i < 35; i++) pulse("tick_to_95", 1'b0);
        chk("at_95", 32'(score_bcd), 32'h0095);
        pulse("point_and_coin", 1'b1);
        chk("sum_106", 32'(score_bcd), 32'h0106);
        chk("sum_106_sat", 32'(saturated), 32'd0);

        for (int i = 0; i < 988; i++) coin("coin_climb");
        for (int i = 0; i < 54; i++) pulse("tick_climb", 1'b0);
        chk("at_9995", 32'(score_bcd), 32'h9995);
        coin("coin_sat");
        chk("sat_score", 32'(score_bcd), 32'h9999);
        chk("sat_flag", 32'(saturated), 32'd1);
        for (int i = 0; i < 6; i++) pulse("tick_sat", 1'b0);
        coin("coin_sat2");
        chk("sat_hold", 32'(score_bcd), 32'h9999);
        end_run();
        check_all("end3");
        chk("end3_new_high", 32'(new_high), 32'd1);

        start_run();
        chk("rerun_sat_clear", 32'(saturated), 32'd0);
        coin("coin_to_10");
        for (int i = 0; i < 42; i++) pulse("tick_to_17", 1'b0);
        chk("at_17", 32'(score_bcd), 32'h0017);
        Reset = 1'b1;
        playing = 1'b1;
        coin_hit = 1'b1;
        step();
        Reset = 1'b0;
        coin_hit = 1'b0;
        playing = 1'b0;
        run_m = 0;
        sc = 0;
        hi = 0;
        check_all("mid_reset");
        chk("mid_reset_new_high", 32'(new_high), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/score_keep_bcd.md
SCORE_KEEP_BCD -- requirements
Module: score_keep_bcd

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of BCD digits in the score, 1..8.
REQ-002 SHALL have parameter TICKS_PER_POINT, default 6: frame ticks per +1 point, 1..255.
REQ-003 SHALL have parameter COIN_BONUS, default 10: points added per coin, 0..10^DIGITS-1.
REQ-004 SHALL have port Clk  input  1: single system clock (50 MHz), all logic on its rising edge.
REQ-005 SHALL have port Reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port frame_clk  input  1: asynchronous frame strobe (VGA_VS), ~60 Hz.
REQ-007 SHALL have port playing  input  1: level, high while the game runs.
REQ-008 SHALL have port coin_hit  input  1: single-Clk pulse, one coin collected.
REQ-009 SHALL have port score_bcd  output  4*DIGITS: current score, packed BCD, digit 0 in bits [3:0].
REQ-010 SHALL have port high_bcd  output  4*DIGITS: best score since reset, packed BCD.
REQ-011 SHALL have port phase  output  2: FSM state, IDLE=0, RUN=1, OVER=2.
REQ-012 SHALL have port new_high  output  1: high while in OVER if the last run set a new best.
REQ-013 SHALL have port saturated  output  1: high while score_bcd is all 9s.

Function
REQ-014 SHALL pass frame_clk through a 2-flop synchroniser plus one history flop; frame_tick = sync2 & ~hist.
REQ-015 SHALL apply a frame_tick score increment at the 3rd rising Clk edge after frame_clk is first sampled high.
REQ-016 SHALL apply a coin_hit bonus at the first rising Clk edge after coin_hit is sampled high.
REQ-017 SHALL detect playing edges with one history flop, with no synchronisation.
REQ-018 SHALL go IDLE->RUN on a playing rising edge, clearing score_bcd, tick counter, new_high and saturated in that same cycle.
REQ-019 SHALL go RUN->OVER on a playing falling edge; if score_bcd > high_bcd, SHALL load high_bcd with score_bcd and set new_high in that same cycle.
REQ-020 SHALL go OVER->RUN on a playing rising edge, with the same clears as REQ-018; high_bcd SHALL be retained.
REQ-021 SHALL count frame_tick in an 8-bit counter only in RUN; at TICKS_PER_POINT-1 the counter SHALL wrap to 0 and raise point_due for that cycle.
REQ-022 SHALL, in RUN, add (point_due ? 1 : 0) + (coin_hit ? COIN_BONUS : 0) in one cycle; a simultaneous point and coin SHALL add 1+COIN_BONUS.
REQ-023 SHALL use decimal carry ripple across all DIGITS digits, giving a valid BCD result each cycle.
REQ-024 SHALL clamp the score at all 9s when the sum overflows 10^DIGITS-1 and assert saturated; score SHALL not wrap.
REQ-025 SHALL ignore frame_tick and coin_hit in IDLE and OVER; score_bcd SHALL hold.
REQ-026 SHALL give the playing edge priority when it coincides with a point or coin: the clear or transition wins and the increment is dropped.
REQ-027 SHALL compare high_bcd digit-wise, most significant digit first.

Reset
REQ-028 SHALL, on Reset, set phase=IDLE and clear score_bcd, high_bcd, tick counter, new_high, saturated and all sync/history flops to 0.
REQ-029 SHALL let Reset override every other input in the same cycle, including Reset mid-RUN.
REQ-030 SHALL clear high_bcd only by Reset.

Verification (DIGITS=4, TICKS_PER_POINT=6, COIN_BONUS=10)
REQ-031 SHALL check: Reset, playing 0->1, 12 frame_clk pulses -> phase=1, score_bcd=16'h0002, 3-cycle latency per REQ-015.
REQ-032 SHALL check: score 16'h0095, coin_hit on the same cycle as point_due -> score_bcd=16'h0106.
REQ-033 SHALL check: score 16'h9995, coin_hit -> score_bcd=16'h9999, saturated=1; further ticks leave it at 16'h9999.
REQ-034 SHALL check: run to 16'h0042, playing 1->0 -> phase=2, high_bcd=16'h0042, new_high=1; rerun to 16'h0030 and end -> high_bcd=16'h0042, new_high=0.
REQ-035 SHALL check: coin_hit and frame_clk pulses during IDLE/OVER -> score_bcd unchanged.
REQ-036 SHALL check: Reset asserted mid-RUN at score 16'h0017 -> next cycle all outputs 0, phase=0.
